alu_uart_if: RTL and testbench

Byte-serial front end for the 8-bit ALU. Collects operand A, operand B and the opcode as three consecutive bytes from a UART receiver, drives them onto the ALU inputs, registers the result, and hands it to a UART transmitter as one response byte. It sits between the UART RX/TX pair and the `alu` instance. It acts as the responder to the host that sends the operand/opcode stream.

---
 rtl/alu_uart_if.sv | 76 +++++++
 tb/tb_alu_uart_if.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_uart_if.sv
// alu_uart_if: collects A, B and opcode bytes from UART RX, drives the ALU, returns the result byte over UART TX.
module alu_uart_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              op_err,
  output logic              overrun
);
  localparam logic [2:0] GET_A   = 3'd0;
  localparam logic [2:0] GET_B   = 3'd1;
  localparam logic [2:0] GET_OP  = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;
  logic [2:0]      r_state;
  logic [OP_W-1:0] w_op;
  logic            w_op_ok;
  logic            w_busy_state;
  assign w_op = rx_data[OP_W-1:0];
  assign w_op_ok = w_op inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b000011, 6'b000010, 6'b100111};
  assign w_busy_state = (r_state == EXEC) || (r_state == SEND) || (r_state == WAIT_TX);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= GET_A;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      op_err   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      op_err   <= 1'b0;
      if (rx_valid && w_busy_state) overrun <= 1'b1;
      case (r_state)
        GET_A: if (rx_valid) begin
          alu_a   <= rx_data;
          r_state <= GET_B;
        end
        GET_B: if (rx_valid) begin
          alu_b   <= rx_data;
          r_state <= GET_OP;
        end
        GET_OP: if (rx_valid) begin
          if (w_op_ok) alu_op <= w_op;
          op_err  <= !w_op_ok;
          r_state <= w_op_ok ? EXEC : GET_A;
        end
        EXEC: begin
          tx_data <= alu_result;
          r_state <= SEND;
        end
        SEND: if (!tx_busy) begin
          tx_start <= 1'b1;
          r_state  <= WAIT_TX;
        end
        WAIT_TX: if (tx_done) r_state <= GET_A;
        default: r_state <= GET_A;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_uart_if.sv
// tb_alu_uart_if: directed frames against alu_uart_if with a small behavioural ALU on the result path.
module tb_alu_uart_if;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, op_err, overrun;
  int checks = 0;
  int errors = 0;
  int n_start = 0;

  alu_uart_if #(.DATA_W(8), .OP_W(6)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_done(tx_done), .alu_result(alu_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .tx_data(tx_data),
    .tx_start(tx_start), .op_err(op_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      6'b100000: alu_result = alu_a + alu_b;
      6'b100010: alu_result = alu_a - alu_b;
      6'b100100: alu_result = alu_a & alu_b;
      6'b100101: alu_result = alu_a | alu_b;
      6'b100110: alu_result = alu_a ^ alu_b;
      6'b100111: alu_result = ~(alu_a | alu_b);
      6'b000010: alu_result = alu_a >> alu_b[2:0];
      6'b000011: alu_result = $signed(alu_a) >>> alu_b[2:0];
      default:   alu_result = 8'h00;
    endcase
  end

  always @(posedge clk) if (tx_start) n_start++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input logic [7:0] exp);
    int s0;
    s0 = n_start;
    send3(a, b, op);
    check({tag, "_start_exec"}, tx_start, 0);
    @(negedge clk);
    check({tag, "_start_send"}, tx_start, 0);
    check({tag, "_data"}, tx_data, exp);
    @(negedge clk);
    check({tag, "_start"}, tx_start, 1);
    @(negedge clk);
    check({tag, "_start_end"}, tx_start, 0);
    pulse_done();
    check({tag, "_nstart"}, n_start - s0, 1);
  endtask

  initial begin
    int s0;
    #1;
    check("rst_a", alu_a, 0);
    check("rst_op", alu_op, 0);
    check("rst_txd", tx_data, 0);
    check("rst_flags", {tx_start, op_err, overrun}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    frame("add", 8'h01, 8'h01, 8'h20, 8'h02);
    check("add_a", alu_a, 8'h01);
    check("add_b", alu_b, 8'h01);
    check("add_op", alu_op, 6'b100000);
    frame("sub", 8'h04, 8'h01, 8'h22, 8'h03);
    frame("nor", 8'hFE, 8'hFE, 8'h27, 8'h01);

    s0 = n_start;
    send3(8'h03, 8'h02, 8'h3F);
    check("inv_err", op_err, 1);
    @(negedge clk);
    check("inv_err_end", op_err, 0);
    repeat (3) @(negedge clk);
    check("inv_nstart", n_start - s0, 0);
    check("inv_op_kept", alu_op, 6'b100111);
    frame("and", 8'h03, 8'h02, 8'h24, 8'h02);
    check("ovr_clear", overrun, 0);

    s0 = n_start;
    tx_busy = 1'b1;
    send3(8'h05, 8'h03, 8'h20);
    for (int i = 0; i < 5; i++) begin
      check("busy_hold", tx_start, 0);
      @(negedge clk);
    end
    tx_busy = 1'b0;
    check("busy_data", tx_data, 8'h08);
    @(negedge clk);
    check("busy_start", tx_start, 1);
    send_byte(8'h77);
    check("busy_start_end", tx_start, 0);
    check("ovr_set", overrun, 1);
    pulse_done();
    check("busy_nstart", n_start - s0, 1);

    frame("or_hi", 8'h04, 8'h03, 8'hE5, 8'h07);
    check("or_hi_a", alu_a, 8'h04);
    check("or_hi_op", alu_op, 6'b100101);
    check("ovr_sticky", overrun, 1);

    send_byte(8'h09);
    send_byte(8'h09);
    #2 reset = 1'b1;
    #1;
    check("mrst_a", alu_a, 0);
    check("mrst_b", alu_b, 0);
    check("mrst_op", alu_op, 0);
    check("mrst_txd", tx_data, 0);
    check("mrst_flags", {tx_start, op_err, overrun}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    frame("xor", 8'h03, 8'h01, 8'h26, 8'h02);

    s0 = n_start;
    tx_busy = 1'b1;
    send3(8'h01, 8'h01, 8'h20);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tx_busy = 1'b0;
    repeat (4) @(negedge clk);
    check("send_rst_nstart", n_start - s0, 0);
    check("send_rst_txd", tx_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
